inst_loader: RTL and testbench

INST_LOADER -- requirements
Module: inst_loader

---
 rtl/riscv_pkg.sv | 77 +++++++
 rtl/inst_loader_if.sv | 34 +++
 rtl/inst_encoder.sv | 71 +++++++
 rtl/inst_loader.sv | 174 +++++++++++++++++
 tb/tb_inst_loader.sv | 322 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32I encoding constants, request-kind and ALU-op encodings, loader
// FSM states and small immediate/ALU helper functions.
package riscv_pkg;

    typedef enum logic [2:0] {
        KIND_R    = 3'd0,
        KIND_I    = 3'd1,
        KIND_LW   = 3'd2,
        KIND_SW   = 3'd3,
        KIND_BEQ  = 3'd4,
        KIND_JAL  = 3'd5,
        KIND_JALR = 3'd6,
        KIND_ILL  = 3'd7
    } kind_e;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_SLT = 3'd4
    } alu_op_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ACCEPT = 3'd1,
        ST_ENCODE = 3'd2,
        ST_WRITE  = 3'd3,
        ST_DONE   = 3'd4,
        ST_ERR    = 3'd5
    } load_state_e;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;
    localparam logic [2:0] F3_LW      = 3'b010;
    localparam logic [2:0] F3_SW      = 3'b010;
    localparam logic [2:0] F3_BEQ     = 3'b000;
    localparam logic [2:0] F3_JALR    = 3'b000;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_SUB  = 7'b0100000;

    function automatic logic fits_s12(input logic [20:0] imm);
        return (imm[20:11] == {10{imm[11]}});
    endfunction

    function automatic logic fits_s13(input logic [20:0] imm);
        return (imm[20:12] == {9{imm[12]}});
    endfunction

    function automatic logic alu_op_legal(input logic [2:0] op);
        return (op <= 3'd4);
    endfunction

    function automatic logic [2:0] alu_funct3(input logic [2:0] op);
        logic [2:0] f3;
        case (op)
            ALU_ADD, ALU_SUB: f3 = F3_ADD_SUB;
            ALU_SLT:          f3 = F3_SLT;
            ALU_OR:           f3 = F3_OR;
            ALU_AND:          f3 = F3_AND;
            default:          f3 = F3_ADD_SUB;
        endcase
        return f3;
    endfunction

endpackage

// File: rtl/inst_loader_if.sv
// Control, request and memory-write signals of the instruction loader.
interface inst_loader_if #(
    parameter int DEPTH = 64
) ();
    localparam int CW = $clog2(DEPTH) + 1;

    logic          i_start;
    logic          o_busy;
    logic          o_done;
    logic          o_err;
    logic          i_valid;
    logic          o_ready;
    logic [2:0]    i_kind;
    logic [2:0]    i_alu_op;
    logic [4:0]    i_rd;
    logic [4:0]    i_rs1;
    logic [4:0]    i_rs2;
    logic [20:0]   i_imm;
    logic          i_last;
    logic          o_we;
    logic [31:0]   o_addr;
    logic [31:0]   o_wdata;
    logic [CW-1:0] o_count;

    modport slave (
        input  i_start, i_valid, i_kind, i_alu_op, i_rd, i_rs1, i_rs2, i_imm, i_last,
        output o_busy, o_done, o_err, o_ready, o_we, o_addr, o_wdata, o_count
    );

    modport master (
        output i_start, i_valid, i_kind, i_alu_op, i_rd, i_rs1, i_rs2, i_imm, i_last,
        input  o_busy, o_done, o_err, o_ready, o_we, o_addr, o_wdata, o_count
    );
endinterface

// File: rtl/inst_encoder.sv
// Combinational RV32I encoder: builds the instruction word for one request
// and flags requests that cannot be encoded.
module inst_encoder
    import riscv_pkg::*;
(
    input  logic [2:0]  kind,
    input  logic [2:0]  alu_op,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [20:0] imm,
    output logic [31:0] word,
    output logic        legal
);

    logic       alu_ok_s;
    logic [2:0] alu_f3_s;
    logic [6:0] f7_s;

    // ALU-op derived fields, only consumed by R and I-ALU kinds
    always_comb begin
        alu_ok_s = alu_op_legal(alu_op);
        alu_f3_s = alu_funct3(alu_op);
        if (alu_op == ALU_SUB) begin
            f7_s = F7_SUB;
        end else begin
            f7_s = F7_BASE;
        end
    end

    // Per-kind field packing and legality
    always_comb begin
        word  = 32'h0000_0000;
        legal = 1'b0;
        case (kind)
            KIND_R: begin
                word  = {f7_s, rs2, rs1, alu_f3_s, rd, OPC_OP};
                legal = alu_ok_s;
            end
            KIND_I: begin
                word  = {imm[11:0], rs1, alu_f3_s, rd, OPC_OP_IMM};
                legal = alu_ok_s && (alu_op != ALU_SUB) && fits_s12(imm);
            end
            KIND_LW: begin
                word  = {imm[11:0], rs1, F3_LW, rd, OPC_LOAD};
                legal = fits_s12(imm);
            end
            KIND_SW: begin
                word  = {imm[11:5], rs2, rs1, F3_SW, imm[4:0], OPC_STORE};
                legal = fits_s12(imm);
            end
            KIND_BEQ: begin
                word  = {imm[12], imm[10:5], rs2, rs1, F3_BEQ, imm[4:1], imm[11], OPC_BRANCH};
                legal = fits_s13(imm) && !imm[0];
            end
            KIND_JAL: begin
                word  = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OPC_JAL};
                legal = !imm[0];
            end
            KIND_JALR: begin
                word  = {imm[11:0], rs1, F3_JALR, rd, OPC_JALR};
                legal = fits_s12(imm);
            end
            default: begin
                word  = 32'h0000_0000;
                legal = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/inst_loader.sv
// Instruction loader: accepts encode requests one at a time, encodes them to
// RV32I words and writes them sequentially into instruction memory.
module inst_loader
    import riscv_pkg::*;
#(
    parameter int          DEPTH     = 64,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    inst_loader_if.slave bus
);

    localparam int            CW        = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] ONE_CNT   = {{(CW-1){1'b0}}, 1'b1};

    load_state_e   state_r;
    load_state_e   state_s;
    logic          xfer_s;
    logic [CW-1:0] count_r;
    logic [CW-1:0] count_inc_s;
    logic [31:0]   addr_off_s;

    logic [2:0]    kind_r;
    logic [2:0]    alu_op_r;
    logic [4:0]    rd_r;
    logic [4:0]    rs1_r;
    logic [4:0]    rs2_r;
    logic [20:0]   imm_r;
    logic          last_r;

    logic [31:0]   enc_word_s;
    logic          enc_legal_s;

    logic          ready_r;
    logic          busy_r;
    logic          done_r;
    logic          err_r;
    logic          we_r;
    logic [31:0]   addr_r;
    logic [31:0]   wdata_r;

    inst_encoder u_encoder (
        .kind   (kind_r),
        .alu_op (alu_op_r),
        .rd     (rd_r),
        .rs1    (rs1_r),
        .rs2    (rs2_r),
        .imm    (imm_r),
        .word   (enc_word_s),
        .legal  (enc_legal_s)
    );

    // Handshake qualifier and write-address arithmetic
    always_comb begin
        xfer_s      = (state_r == ST_ACCEPT) && bus.i_valid && !bus.i_start;
        count_inc_s = count_r + ONE_CNT;
        addr_off_s  = {{(30-CW){1'b0}}, count_r, 2'b00};
    end

    // Next-state logic; i_start restarts the session from any state
    always_comb begin
        state_s = state_r;
        if (bus.i_start) begin
            state_s = ST_ACCEPT;
        end else begin
            case (state_r)
                ST_IDLE:   state_s = ST_IDLE;
                ST_ACCEPT: begin
                    if (bus.i_valid) begin
                        state_s = ST_ENCODE;
                    end else begin
                        state_s = ST_ACCEPT;
                    end
                end
                ST_ENCODE: begin
                    if (enc_legal_s) begin
                        state_s = ST_WRITE;
                    end else begin
                        state_s = ST_ERR;
                    end
                end
                ST_WRITE: begin
                    if (last_r || (count_inc_s == DEPTH_CNT)) begin
                        state_s = ST_DONE;
                    end else begin
                        state_s = ST_ACCEPT;
                    end
                end
                ST_DONE:   state_s = ST_DONE;
                ST_ERR:    state_s = ST_ERR;
                default:   state_s = ST_IDLE;
            endcase
        end
    end

    // FSM state register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Request field capture on handshake
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            kind_r   <= 3'd0;
            alu_op_r <= 3'd0;
            rd_r     <= 5'd0;
            rs1_r    <= 5'd0;
            rs2_r    <= 5'd0;
            imm_r    <= 21'd0;
            last_r   <= 1'b0;
        end else if (xfer_s) begin
            kind_r   <= bus.i_kind;
            alu_op_r <= bus.i_alu_op;
            rd_r     <= bus.i_rd;
            rs1_r    <= bus.i_rs1;
            rs2_r    <= bus.i_rs2;
            imm_r    <= bus.i_imm;
            last_r   <= bus.i_last;
        end
    end

    // Word counter, address and encoded-word registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            count_r <= {CW{1'b0}};
            addr_r  <= 32'h0000_0000;
            wdata_r <= 32'h0000_0000;
        end else if (bus.i_start) begin
            count_r <= {CW{1'b0}};
        end else begin
            if (state_r == ST_WRITE) begin
                count_r <= count_inc_s;
            end
            if ((state_r == ST_ENCODE) && enc_legal_s) begin
                addr_r  <= BASE_ADDR + addr_off_s;
                wdata_r <= enc_word_s;
            end
        end
    end

    // Status outputs registered from the next state
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ready_r <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            err_r   <= 1'b0;
            we_r    <= 1'b0;
        end else begin
            ready_r <= (state_s == ST_ACCEPT);
            busy_r  <= (state_s == ST_ACCEPT) || (state_s == ST_ENCODE) || (state_s == ST_WRITE);
            done_r  <= (state_s == ST_DONE);
            err_r   <= (state_s == ST_ERR);
            we_r    <= (state_s == ST_WRITE);
        end
    end

    // A restart during WRITE must suppress the strobe already on the bus
    assign bus.o_we    = we_r & ~bus.i_start;
    assign bus.o_ready = ready_r;
    assign bus.o_busy  = busy_r;
    assign bus.o_done  = done_r;
    assign bus.o_err   = err_r;
    assign bus.o_addr  = addr_r;
    assign bus.o_wdata = wdata_r;
    assign bus.o_count = count_r;

endmodule

// File: tb/tb_inst_loader.sv
// Self-checking bench for inst_loader: expected memory writes are queued when
// requests are issued and matched against each o_we strobe.
module tb_inst_loader;
    import riscv_pkg::*;

    localparam int DEPTH = 4;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;
    wr_t  sb[$];

    inst_loader_if #(.DEPTH(DEPTH)) bus ();

    inst_loader #(.DEPTH(DEPTH), .BASE_ADDR(32'h0000_0000)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: time %0t reached, required completion earlier", $time);
        $fatal(1, "watchdog expired");
    end

    // Scoreboard: every strobe must match the oldest queued expectation
    always @(negedge clk) begin
        wr_t e;
        if (bus.o_we === 1'b1) begin
            n_cmp++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_write: addr=%h data=%h, required no write", bus.o_addr, bus.o_wdata);
            end else begin
                e = sb.pop_front();
                if (bus.o_addr !== e.addr || bus.o_wdata !== e.data) begin
                    n_err++;
                    $display("FAIL write_check: addr=%h data=%h, required addr=%h data=%h",
                             bus.o_addr, bus.o_wdata, e.addr, e.data);
                end
            end
        end
    end

    task automatic start_session();
        bus.i_start = 1'b1;
        @(posedge clk); #1;
        bus.i_start = 1'b0;
    endtask

    task automatic send_req(input logic [2:0] kind, input logic [2:0] op, input logic [4:0] rd,
                            input logic [4:0] rs1, input logic [4:0] rs2, input logic [20:0] imm,
                            input logic last, input logic exp_wr, input logic [31:0] exp_addr,
                            input logic [31:0] exp_data);
        bit got;
        got = 1'b0;
        bus.i_valid = 1'b1; bus.i_kind = kind; bus.i_alu_op = op; bus.i_rd = rd;
        bus.i_rs1 = rs1; bus.i_rs2 = rs2; bus.i_imm = imm; bus.i_last = last;
        for (int i = 0; i < 20 && !got; i++) begin
            if (bus.o_ready === 1'b1) begin
                if (exp_wr) sb.push_back({exp_addr, exp_data});
                got = 1'b1;
            end
            @(posedge clk); #1;
        end
        bus.i_valid = 1'b0;
        n_cmp++;
        if (!got) begin
            n_err++;
            $display("FAIL send_timeout: o_ready=%b, required 1 within 20 cycles", bus.o_ready);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.i_start = 1'b1; bus.i_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({bus.o_ready, bus.o_we, bus.o_busy, bus.o_done, bus.o_err} !== 5'b0 ||
            bus.o_addr !== 32'h0 || bus.o_wdata !== 32'h0 || bus.o_count !== 3'd0) begin
            n_err++;
            $display("FAIL reset_outputs: rdy/we/busy/done/err=%b addr=%h data=%h cnt=%0d, required all 0",
                     {bus.o_ready, bus.o_we, bus.o_busy, bus.o_done, bus.o_err}, bus.o_addr, bus.o_wdata, bus.o_count);
        end
        bus.i_start = 1'b0;
        rst_n = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            n_cmp++;
            if (bus.o_ready !== 1'b0 || bus.o_busy !== 1'b0) begin
                n_err++;
                $display("FAIL idle_ignores_valid: ready=%b busy=%b, required 0 0", bus.o_ready, bus.o_busy);
            end
        end
        bus.i_valid = 1'b0;
    endtask

    task automatic test_r_type();
        start_session();
        n_cmp++;
        if ({bus.o_ready, bus.o_busy, bus.o_done} !== 3'b110 || bus.o_count !== 3'd0) begin
            n_err++;
            $display("FAIL accept_state: rdy/busy/done=%b cnt=%0d, required 110 0", {bus.o_ready, bus.o_busy, bus.o_done}, bus.o_count);
        end
        send_req(KIND_R, ALU_ADD, 5'd3, 5'd1, 5'd2, 21'd0, 1'b1, 1'b1, 32'h0, 32'h002081B3);
        n_cmp++;
        if (bus.o_we !== 1'b0 || bus.o_ready !== 1'b0) begin
            n_err++;
            $display("FAIL encode_cycle: we=%b ready=%b, required 0 0", bus.o_we, bus.o_ready);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (bus.o_we !== 1'b1) begin
            n_err++;
            $display("FAIL strobe_latency: we=%b two cycles after transfer, required 1", bus.o_we);
        end
        @(posedge clk); #1;
        n_cmp++;
        if ({bus.o_done, bus.o_busy, bus.o_ready, bus.o_err, bus.o_we} !== 5'b10000 || bus.o_count !== 3'd1) begin
            n_err++;
            $display("FAIL add_done: done/busy/rdy/err/we=%b cnt=%0d, required 10000 1",
                     {bus.o_done, bus.o_busy, bus.o_ready, bus.o_err, bus.o_we}, bus.o_count);
        end
        start_session();
        n_cmp++;
        if (bus.o_done !== 1'b0 || bus.o_count !== 3'd0) begin
            n_err++;
            $display("FAIL restart_clears: done=%b cnt=%0d, required 0 0", bus.o_done, bus.o_count);
        end
        send_req(KIND_R, ALU_SUB, 5'd3, 5'd1, 5'd2, 21'd0, 1'b1, 1'b1, 32'h0, 32'h402081B3);
        repeat (3) @(posedge clk);
        #1;
        start_session();
        send_req(KIND_R, ALU_AND, 5'd3, 5'd1, 5'd2, 21'd0, 1'b0, 1'b1, 32'h0, 32'h0020F1B3);
        send_req(KIND_R, ALU_OR,  5'd3, 5'd1, 5'd2, 21'd0, 1'b0, 1'b1, 32'h4, 32'h0020E1B3);
        send_req(KIND_R, ALU_SLT, 5'd3, 5'd1, 5'd2, 21'd0, 1'b1, 1'b1, 32'h8, 32'h0020A1B3);
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (bus.o_done !== 1'b1 || bus.o_count !== 3'd3 || sb.size() != 0) begin
            n_err++;
            $display("FAIL r_session: done=%b cnt=%0d pending=%0d, required 1 3 0", bus.o_done, bus.o_count, sb.size());
        end
    endtask

    task automatic test_mixed_kinds();
        start_session();
        send_req(KIND_JAL, ALU_ADD, 5'd1, 5'd0, 5'd0, 21'd8, 1'b0, 1'b1, 32'h0, 32'h008000EF);
        send_req(KIND_LW,  ALU_ADD, 5'd5, 5'd0, 5'd0, 21'd8, 1'b1, 1'b1, 32'h4, 32'h00802283);
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (bus.o_done !== 1'b1 || bus.o_count !== 3'd2) begin
            n_err++;
            $display("FAIL lw_second: done=%b cnt=%0d, required 1 2", bus.o_done, bus.o_count);
        end
        start_session();
        send_req(KIND_SW,   ALU_ADD, 5'd31, 5'd2, 5'd5,  21'd12,      1'b0, 1'b1, 32'h0, 32'h00512623);
        send_req(KIND_I,    ALU_ADD, 5'd1,  5'd0, 5'd31, 21'h1FFFFF,  1'b0, 1'b1, 32'h4, 32'hFFF00093);
        send_req(KIND_I,    ALU_SLT, 5'd2,  5'd1, 5'd9,  21'd5,       1'b0, 1'b1, 32'h8, 32'h0050A113);
        send_req(KIND_JALR, ALU_OR,  5'd0,  5'd1, 5'd7,  21'd0,       1'b1, 1'b1, 32'hC, 32'h00008067);
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (bus.o_done !== 1'b1 || bus.o_count !== 3'd4 || sb.size() != 0) begin
            n_err++;
            $display("FAIL mixed_session: done=%b cnt=%0d pending=%0d, required 1 4 0", bus.o_done, bus.o_count, sb.size());
        end
    endtask

    task automatic test_imm_boundaries();
        start_session();
        send_req(KIND_LW,  ALU_ADD, 5'd5, 5'd0, 5'd0, 21'd2047,    1'b0, 1'b1, 32'h0, 32'h7FF02283);
        send_req(KIND_LW,  ALU_ADD, 5'd5, 5'd0, 5'd0, 21'h1FF800,  1'b0, 1'b1, 32'h4, 32'h80002283);
        send_req(KIND_BEQ, ALU_ADD, 5'd0, 5'd1, 5'd2, 21'h1FFFFC,  1'b0, 1'b1, 32'h8, 32'hFE208EE3);
        send_req(KIND_BEQ, ALU_ADD, 5'd0, 5'd1, 5'd2, 21'd4094,    1'b0, 1'b1, 32'hC, 32'h7E208FE3);
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (bus.o_done !== 1'b1 || bus.o_err !== 1'b0 || bus.o_count !== 3'd4) begin
            n_err++;
            $display("FAIL imm_boundaries: done=%b err=%b cnt=%0d, required 1 0 4", bus.o_done, bus.o_err, bus.o_count);
        end
    endtask

    task automatic test_illegal();
        logic [2:0]  ill_kind [0:8];
        logic [2:0]  ill_op   [0:8];
        logic [20:0] ill_imm  [0:8];
        ill_kind = '{KIND_ILL, KIND_R, KIND_I, KIND_LW, KIND_BEQ, KIND_BEQ, KIND_JAL, KIND_SW, KIND_JALR};
        ill_op   = '{3'd0, 3'd5, 3'd1, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0};
        ill_imm  = '{21'd0, 21'd0, 21'd0, 21'd2048, 21'd3, 21'd4096, 21'd1, 21'h1FF7FF, 21'd2048};
        for (int k = 0; k < 9; k++) begin
            start_session();
            send_req(ill_kind[k], ill_op[k], 5'd3, 5'd1, 5'd2, ill_imm[k], 1'b1, 1'b0, 32'h0, 32'h0);
            repeat (3) @(posedge clk);
            #1;
            n_cmp++;
            if ({bus.o_err, bus.o_done, bus.o_busy, bus.o_ready} !== 4'b1000 || bus.o_count !== 3'd0) begin
                n_err++;
                $display("FAIL illegal_%0d: err/done/busy/rdy=%b cnt=%0d, required 1000 0",
                         k, {bus.o_err, bus.o_done, bus.o_busy, bus.o_ready}, bus.o_count);
            end
        end
    endtask

    task automatic test_depth_cap();
        start_session();
        for (int k = 0; k < 4; k++) begin
            send_req(KIND_R, ALU_ADD, 5'd3, 5'd1, 5'd2, 21'd0, 1'b0, 1'b1, 32'(4 * k), 32'h002081B3);
        end
        bus.i_valid = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        bus.i_valid = 1'b0;
        n_cmp++;
        if ({bus.o_done, bus.o_ready, bus.o_busy} !== 3'b100 || bus.o_count !== 3'd4 || sb.size() != 0) begin
            n_err++;
            $display("FAIL depth_cap: done/rdy/busy=%b cnt=%0d pending=%0d, required 100 4 0",
                     {bus.o_done, bus.o_ready, bus.o_busy}, bus.o_count, sb.size());
        end
    endtask

    task automatic test_abort_write();
        start_session();
        send_req(KIND_R, ALU_ADD, 5'd3, 5'd1, 5'd2, 21'd0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(posedge clk); #1;
        bus.i_start = 1'b1;
        #1;
        n_cmp++;
        if (bus.o_we !== 1'b0) begin
            n_err++;
            $display("FAIL abort_strobe: we=%b with i_start in WRITE, required 0", bus.o_we);
        end
        @(posedge clk); #1;
        bus.i_start = 1'b0;
        n_cmp++;
        if ({bus.o_ready, bus.o_busy, bus.o_done} !== 3'b110 || bus.o_count !== 3'd0) begin
            n_err++;
            $display("FAIL abort_state: rdy/busy/done=%b cnt=%0d, required 110 0", {bus.o_ready, bus.o_busy, bus.o_done}, bus.o_count);
        end
        send_req(KIND_LW, ALU_ADD, 5'd5, 5'd0, 5'd0, 21'd8, 1'b1, 1'b1, 32'h0, 32'h00802283);
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (bus.o_done !== 1'b1 || bus.o_count !== 3'd1) begin
            n_err++;
            $display("FAIL abort_recover: done=%b cnt=%0d, required 1 1", bus.o_done, bus.o_count);
        end
    endtask

    task automatic test_reset_mid_encode();
        start_session();
        send_req(KIND_R, ALU_ADD, 5'd3, 5'd1, 5'd2, 21'd0, 1'b1, 1'b0, 32'h0, 32'h0);
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({bus.o_ready, bus.o_we, bus.o_busy, bus.o_done, bus.o_err} !== 5'b0 || bus.o_count !== 3'd0 ||
            bus.o_addr !== 32'h0 || bus.o_wdata !== 32'h0) begin
            n_err++;
            $display("FAIL async_reset: rdy/we/busy/done/err=%b cnt=%0d addr=%h data=%h, required all 0",
                     {bus.o_ready, bus.o_we, bus.o_busy, bus.o_done, bus.o_err}, bus.o_count, bus.o_addr, bus.o_wdata);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({bus.o_ready, bus.o_busy, bus.o_done, bus.o_err} !== 4'b0 || bus.o_count !== 3'd0) begin
            n_err++;
            $display("FAIL post_reset_idle: rdy/busy/done/err=%b cnt=%0d, required 0000 0",
                     {bus.o_ready, bus.o_busy, bus.o_done, bus.o_err}, bus.o_count);
        end
        start_session();
        send_req(KIND_R, ALU_ADD, 5'd3, 5'd1, 5'd2, 21'd0, 1'b1, 1'b1, 32'h0, 32'h002081B3);
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (bus.o_done !== 1'b1 || bus.o_count !== 3'd1 || sb.size() != 0) begin
            n_err++;
            $display("FAIL reset_recover: done=%b cnt=%0d pending=%0d, required 1 1 0", bus.o_done, bus.o_count, sb.size());
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        bus.i_start = 1'b0; bus.i_valid = 1'b0; bus.i_kind = 3'd0; bus.i_alu_op = 3'd0;
        bus.i_rd = 5'd0; bus.i_rs1 = 5'd0; bus.i_rs2 = 5'd0; bus.i_imm = 21'd0; bus.i_last = 1'b0;
        @(posedge clk); #1;
        test_reset();
        test_r_type();
        test_mixed_kinds();
        test_imm_boundaries();
        test_illegal();
        test_depth_cap();
        test_abort_write();
        test_reset_mid_encode();
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL final_queue: pending=%0d, required 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
